// File: rtl/serial_frame_loader.sv
// Serial frame loader: captures a dynamic and a static word on START and shifts them
// MSB-first to the shift-register generator, then strobes a commit and pulses DONE.
module serial_frame_loader #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int SIZECNT    = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [SIZESRDYN-1:0]  i_dyn_data,
  input  logic [SIZESRSTAT-1:0] i_stat_data,
  output logic                  o_seldyn,
  output logic                  o_selstat,
  output logic                  o_sdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DYN    = 3'd1,
    S_STAT   = 3'd2,
    S_COMMIT = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [SIZECNT-1:0] DYN_LAST  = SIZECNT'(SIZESRDYN - 1);
  localparam logic [SIZECNT-1:0] STAT_LAST = SIZECNT'(SIZESRSTAT - 1);

  state_t                r_state;
  logic [SIZECNT-1:0]    r_cnt;
  logic [SIZESRDYN-1:0]  r_dyn;
  logic [SIZESRSTAT-1:0] r_stat;

  // Shadows shift left so the next bit to send is always the MSB; the
  // counter only decides when a phase ends.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dyn     <= '0;
      r_stat    <= '0;
      o_seldyn  <= 1'b0;
      o_selstat <= 1'b0;
      o_sdata   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state   <= S_DYN;
            r_cnt     <= DYN_LAST;
            r_dyn     <= {i_dyn_data[SIZESRDYN-2:0], 1'b0};
            r_stat    <= i_stat_data;
            o_seldyn  <= 1'b1;
            o_selstat <= 1'b0;
            o_sdata   <= i_dyn_data[SIZESRDYN-1];
            o_busy    <= 1'b1;
          end
        end
        S_DYN: begin
          if (i_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_seldyn  <= 1'b0;
            o_selstat <= 1'b0;
            o_sdata   <= 1'b0;
            o_busy    <= 1'b0;
          end else if (r_cnt == '0) begin
            // Switch selects in the same edge: a cycle with both low would
            // make the generator reload its registers.
            r_state   <= S_STAT;
            r_cnt     <= STAT_LAST;
            r_stat    <= {r_stat[SIZESRSTAT-2:0], 1'b0};
            o_seldyn  <= 1'b0;
            o_selstat <= 1'b1;
            o_sdata   <= r_stat[SIZESRSTAT-1];
          end else begin
            r_cnt   <= r_cnt - 1'b1;
            r_dyn   <= {r_dyn[SIZESRDYN-2:0], 1'b0};
            o_sdata <= r_dyn[SIZESRDYN-1];
          end
        end
        S_STAT: begin
          if (i_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_seldyn  <= 1'b0;
            o_selstat <= 1'b0;
            o_sdata   <= 1'b0;
            o_busy    <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state   <= S_COMMIT;
            o_seldyn  <= 1'b1;
            o_selstat <= 1'b0;
            o_sdata   <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
            r_stat  <= {r_stat[SIZESRSTAT-2:0], 1'b0};
            o_sdata <= r_stat[SIZESRSTAT-1];
          end
        end
        S_COMMIT: begin
          r_state   <= i_abort ? S_IDLE : S_FIN;
          o_seldyn  <= 1'b0;
          o_selstat <= 1'b0;
          o_sdata   <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= ~i_abort;
        end
        S_FIN: begin
          r_state <= S_IDLE;
          o_done  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          o_seldyn  <= 1'b0;
          o_selstat <= 1'b0;
          o_sdata   <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed bench for serial_frame_loader: table of frames checked cycle by cycle against
// a frame model, plus hand-written reset, abort and mid-frame perturbation sequences.
module tb_serial_frame_loader;
  localparam int DW = 16;
  localparam int SW = 88;
  localparam int FRAME_SAMPLES = 107;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [DW-1:0] dyn;
  logic [SW-1:0] stat;
  logic          seldyn, selstat, sdata, busy, done;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {seldyn, selstat, sdata, busy, done} per sampled cycle
  logic [4:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] dyn;
    logic [SW-1:0] stat;
  } frame_vec_t;

  frame_vec_t frames[4];

  always #5 clk = ~clk;

  serial_frame_loader #(.SIZESRDYN(DW), .SIZESRSTAT(SW), .SIZECNT(7)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_dyn_data  (dyn),
    .i_stat_data (stat),
    .o_seldyn    (seldyn),
    .o_selstat   (selstat),
    .o_sdata     (sdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_dbg_state (dbg_state)
  );

  function automatic logic [4:0] outs();
    return {seldyn, selstat, sdata, busy, done};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample k=1 is the cycle right after the accepting edge.
  task automatic model_frame(input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int k = 1; k <= FRAME_SAMPLES; k++) begin
      if (k <= 16)       exp_q.push_back({1'b1, 1'b0, d[16-k], 1'b1, 1'b0});
      else if (k <= 104) exp_q.push_back({1'b0, 1'b1, s[104-k], 1'b1, 1'b0});
      else if (k == 105) exp_q.push_back(5'b10010);
      else if (k == 106) exp_q.push_back(5'b00001);
      else               exp_q.push_back(5'b00000);
    end
  endtask

  // Caller drives start=1 and the data at a negedge before calling. Inside the frame
  // the inputs are scrambled and extra STARTs are issued (DYN, STAT, COMMIT, FIN).
  task automatic full_frame(input logic [DW-1:0] d, input logic [SW-1:0] s, input string tag);
    logic [DW-1:0] dcap;
    logic [SW-1:0] scap;
    logic [4:0]    e;
    int            busy_cnt;
    int            done_cnt;
    dcap = '0;
    scap = '0;
    busy_cnt = 0;
    done_cnt = 0;
    model_frame(d, s);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= FRAME_SAMPLES; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s cycle %0d outputs", tag, k), 128'(outs()), 128'(e));
      if (seldyn && selstat) chk($sformatf("%s cycle %0d both selects", tag, k), 128'(1), 128'(0));
      if (seldyn && k <= 16) dcap = {dcap[DW-2:0], sdata};
      if (selstat) scap = {scap[SW-2:0], sdata};
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (k == 3) begin
        dyn  = ~d;
        stat = ~s;
      end
      start = (k == 5 || k == 50 || k == 105 || k == 106);
      if (k < FRAME_SAMPLES) @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " dynlatch"}, 128'(dcap), 128'(d));
    chk({tag, " statlatch"}, 128'(scap), 128'(s));
    chk({tag, " busy cycles"}, 128'(busy_cnt), 128'(105));
    chk({tag, " done pulses"}, 128'(done_cnt), 128'(1));
  endtask

  // Runs the first n sampled cycles of a frame against the model, then drops the rest.
  task automatic partial_frame(input logic [DW-1:0] d, input logic [SW-1:0] s, input int n,
                               input string tag);
    logic [4:0] e;
    model_frame(d, s);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s cycle %0d outputs", tag, k), 128'(outs()), 128'(e));
      if (k < n) @(negedge clk);
    end
    exp_q.delete();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    dyn   = 16'hABCD;
    stat  = 88'h123456789ABCDEF1234567;

    frames[0] = '{dyn: 16'hABCD, stat: 88'h123456789ABCDEF1234567};
    frames[1] = '{dyn: 16'h0000, stat: {SW{1'b1}}};
    frames[2] = '{dyn: 16'hFFFF, stat: {SW{1'b0}}};
    frames[3] = '{dyn: 16'h8001, stat: 88'h8000000000000000000001};

    // Reset held for two edges with START high
    repeat (2) @(negedge clk);
    chk("reset outputs", 128'(outs()), 128'(0));
    chk("reset state", 128'(dbg_state), 128'(0));
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-reset idle outputs", 128'(outs()), 128'(0));
      chk("post-reset idle state", 128'(dbg_state), 128'(0));
    end

    // Table of frames, issued back-to-back in the IDLE cycle after FIN
    for (int i = 0; i < 4; i++) begin
      dyn   = frames[i].dyn;
      stat  = frames[i].stat;
      start = 1'b1;
      full_frame(frames[i].dyn, frames[i].stat, $sformatf("frame%0d", i));
    end

    // Abort during STAT; ABORT in IDLE afterwards has no effect
    dyn   = 16'h5A3C;
    stat  = 88'hF0E1D2C3B4A5968778695A;
    start = 1'b1;
    partial_frame(16'h5A3C, 88'hF0E1D2C3B4A5968778695A, 30, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort cycle 31 outputs", 128'(outs()), 128'(0));
    chk("abort cycle 31 state", 128'(dbg_state), 128'(0));
    for (int k = 32; k < 40; k++) begin
      abort = (k == 35);
      @(negedge clk);
      chk($sformatf("after abort cycle %0d outputs", k), 128'(outs()), 128'(0));
    end
    abort = 1'b0;
    dyn   = 16'h1357;
    stat  = 88'h2468ACE02468ACE02468AC;
    start = 1'b1;
    full_frame(16'h1357, 88'h2468ACE02468ACE02468AC, "post-abort");

    // Reset during STAT, coinciding with ABORT and START
    dyn   = 16'hC3A5;
    stat  = 88'h0F1E2D3C4B5A69788796A5;
    start = 1'b1;
    partial_frame(16'hC3A5, 88'h0F1E2D3C4B5A69788796A5, 60, "reset-mid");
    rst   = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    chk("reset-mid cycle 61 outputs", 128'(outs()), 128'(0));
    chk("reset-mid cycle 61 state", 128'(dbg_state), 128'(0));
    for (int k = 62; k < 66; k++) begin
      @(negedge clk);
      chk($sformatf("after reset cycle %0d outputs", k), 128'(outs()), 128'(0));
    end
    dyn   = 16'hABCD;
    stat  = 88'h123456789ABCDEF1234567;
    start = 1'b1;
    full_frame(16'hABCD, 88'h123456789ABCDEF1234567, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_loader.md
Name: serial_frame_loader

Overview:
Upstream feeder for the serial shift-register generator. Captures one parallel frame, a dynamic word and a static word, on a START request. Shifts the frame out MSB-first on SDATA with the select strobes the generator expects. Ends with a one-cycle commit strobe so the generator's static latch captures the shifted static word.

Parameters:
SIZESRDYN, 16, dynamic word length (bits)
SIZESRSTAT, 88, static word length (bits)
SIZECNT, 7, bit-counter width; must satisfy 2^SIZECNT >= max(SIZESRDYN, SIZESRSTAT)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  reset, synchronous, active-high
START  input  1  frame request; sampled only in IDLE
ABORT  input  1  synchronous abort of a frame in progress
DYN_DATA  input  SIZESRDYN  dynamic word; captured when START is accepted
STAT_DATA  input  SIZESRSTAT  static word; captured when START is accepted
SELDYN  output  1  dynamic-shift select to generator
SELSTAT  output  1  static-shift select to generator
SDATA  output  1  serial data to generator signal_in
BUSY  output  1  high while a frame is in progress
DONE  output  1  one-cycle pulse on normal frame completion

Behaviour:
- Reset: RST sampled high at a rising edge forces state IDLE. All outputs go 0, counter 0, shadow registers 0. Reset mid-frame aborts immediately and produces no DONE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, DYN, STAT, COMMIT, FIN.
- IDLE: SELDYN=SELSTAT=SDATA=BUSY=DONE=0.
  - START=1 at edge t: capture DYN_DATA/STAT_DATA into shadows, counter=SIZESRDYN-1, go to DYN.
  - Outputs change at t: SELDYN=1, SELSTAT=0, BUSY=1, SDATA=DYN_DATA[SIZESRDYN-1].
- DYN: SELDYN=1, SELSTAT=0, SDATA=dyn shadow[counter], counter decrements each cycle.
  - When counter=0: load counter=SIZESRSTAT-1 and go to STAT.
  - The next cycle shows SELSTAT=1, SELDYN=0, SDATA=STAT bit MSB.
  - No idle gap is allowed between DYN and STAT, because both selects low reloads the generator's registers.
- STAT: SELSTAT=1, SELDYN=0, SDATA=stat shadow[counter], counter decrements.
  - When counter=0: go to COMMIT.
- COMMIT (1 cycle): SELDYN=1, SELSTAT=0, SDATA=0. This latches the generator's static latch.
- FIN (1 cycle): DONE=1, BUSY=0, selects=0, SDATA=0. Next state is IDLE.
- Frame timing, with START accepted at edge 0 and cycles numbered after each edge:
  - DYN: cycles 1..16
  - STAT: cycles 17..104
  - COMMIT: cycle 105
  - DONE: cycle 106
  - Total BUSY cycles = SIZESRDYN+SIZESRSTAT+1 = 105.
- START while BUSY or in FIN: ignored, not queued. START in the IDLE cycle following FIN is accepted, giving back-to-back frames with a 2-cycle gap.
- ABORT=1 in DYN/STAT/COMMIT: next cycle goes to IDLE with all outputs 0 and no DONE. ABORT in IDLE or FIN: no effect.
- Priority when events coincide: RST > ABORT > START.
- SELDYN and SELSTAT are never both 1, in any state or cycle.
- DYN_DATA/STAT_DATA changes after acceptance do not affect the frame in progress.
- Counter never underflows: wrap from 0 is replaced by the phase transition.

Test Plan:
1. RST=1 for 2 cycles with START=1 -> all outputs 0; after release with START=0, state remains IDLE.
2. DYN_DATA=16'hABCD, STAT_DATA=88'h123456789ABCDEF1234567, single START pulse:
   - SDATA over cycles 1..16 = 1010101111001101 with SELDYN=1.
   - Cycles 17..104 carry the static bits MSB-first with SELSTAT=1.
   - Cycle 105: SELDYN=1, SDATA=0.
   - DONE=1 only at cycle 106; BUSY high for exactly 105 cycles.
3. Same frame driven into the generator model -> after COMMIT, DYNLATCH=16'hABCD and STATLATCH=88'h123456789ABCDEF1234567.
4. START pulses at cycles 5 and 50, and DYN_DATA changed at cycle 3 -> single frame, shifted bits still from the original capture, exactly one DONE.
5. ABORT=1 at cycle 30 -> cycle 31 shows all outputs 0; no DONE; a new START at cycle 40 begins a clean frame with SELDYN=1 at cycle 41.
6. RST=1 at cycle 60 of a frame -> next cycle all outputs 0; no DONE; a following START produces a full 105-cycle frame.
